// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings, default-slave state type and the region
// match helper used by the decoder/mux slice.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    DS_IDLE = 2'b00,
    DS_ERR1 = 2'b01,
    DS_ERR2 = 2'b10
  } ds_state_e;

  // Inclusive on both ends, so a region ending at 0xFFFF_FFFF needs no wrap handling.
  function automatic logic addr_in_range(input logic [31:0] addr,
                                         input logic [31:0] lo,
                                         input logic [31:0] hi);
    return (addr >= lo) && (addr <= hi);
  endfunction

endpackage

// File: rtl/ahb_default_slave.sv
// Built-in default slave: answers unmapped NONSEQ/SEQ transfers with a
// two-cycle ERROR response and unmapped IDLE/BUSY with a zero-wait OKAY.
module ahb_default_slave
  import ahb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sel_default,
  input  logic [1:0] htrans,
  input  logic       hready_in,
  output logic       hready,
  output logic       hresp
);

  ds_state_e state_q, state_d;
  logic      hready_q, hready_d;
  logic      hresp_q, hresp_d;
  logic      active;
  logic      err_start;

  always_comb begin
    active = 1'b0;
    case (htrans)
      HTRANS_NONSEQ, HTRANS_SEQ: active = 1'b1;
      HTRANS_IDLE, HTRANS_BUSY:  active = 1'b0;
      default:                   active = 1'b0;
    endcase
    err_start = hready_in && sel_default && active;
  end

  // Outputs are derived from the next state so they are registered with it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      DS_IDLE: if (err_start) state_d = DS_ERR1;
      DS_ERR1: state_d = DS_ERR2;
      DS_ERR2: state_d = err_start ? DS_ERR1 : DS_IDLE;
      default: state_d = DS_IDLE;
    endcase
    hready_d = (state_d != DS_ERR1);
    hresp_d  = (state_d == DS_IDLE) ? HRESP_OKAY : HRESP_ERROR;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= DS_IDLE;
      hready_q <= 1'b1;
      hresp_q  <= HRESP_OKAY;
    end else begin
      state_q  <= state_d;
      hready_q <= hready_d;
      hresp_q  <= hresp_d;
    end
  end

  assign hready = hready_q;
  assign hresp  = hresp_q;

endmodule

// File: rtl/ahb_decoder_mux.sv
// AHB-Lite address decoder plus slave response multiplexer for one master
// layer; unmapped space is served by the built-in default slave.
module ahb_decoder_mux
  import ahb_pkg::*;
#(
  parameter int          NUM_SLAVES = 4,
  parameter int          DATA_WIDTH = 32,
  parameter logic [31:0] START_ADDR [0:NUM_SLAVES-1] = '{default: 32'h0},
  parameter logic [31:0] END_ADDR   [0:NUM_SLAVES-1] = '{default: 32'h0}
) (
  input  logic                             i_hclk,
  input  logic                             i_hresetn,
  input  logic [31:0]                      i_haddr,
  input  logic [1:0]                       i_htrans,
  output logic [NUM_SLAVES-1:0]            o_hsel,
  input  logic [NUM_SLAVES-1:0]            i_hreadyout_s,
  input  logic [NUM_SLAVES-1:0]            i_hresp_s,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] i_hrdata_s,
  output logic                             o_hready,
  output logic                             o_hresp,
  output logic [DATA_WIDTH-1:0]            o_hrdata
);

  logic [NUM_SLAVES:0] dsel_q, dsel_d;
  logic                found;
  logic                sel_default;
  logic                ds_hready;
  logic                ds_hresp;

  // Lowest matching index wins, keeping o_hsel one-hot or zero on overlaps.
  always_comb begin
    o_hsel = '0;
    found  = 1'b0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (!found && addr_in_range(i_haddr, START_ADDR[i], END_ADDR[i])) begin
        o_hsel[i] = 1'b1;
        found     = 1'b1;
      end
    end
    sel_default = !found;
  end

  always_comb begin
    dsel_d = o_hready ? {sel_default, o_hsel} : dsel_q;
  end

  always_ff @(posedge i_hclk or negedge i_hresetn) begin
    if (!i_hresetn) begin
      dsel_q <= {1'b1, {NUM_SLAVES{1'b0}}};
    end else begin
      dsel_q <= dsel_d;
    end
  end

  ahb_default_slave u_default_slave (
    .clk         (i_hclk),
    .rst_n       (i_hresetn),
    .sel_default (sel_default),
    .htrans      (i_htrans),
    .hready_in   (o_hready),
    .hready      (ds_hready),
    .hresp       (ds_hresp)
  );

  always_comb begin
    o_hready = 1'b1;
    o_hresp  = HRESP_OKAY;
    o_hrdata = '0;
    if (dsel_q[NUM_SLAVES]) begin
      o_hready = ds_hready;
      o_hresp  = ds_hresp;
    end
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (dsel_q[i]) begin
        o_hready = i_hreadyout_s[i];
        o_hresp  = i_hresp_s[i];
        o_hrdata = i_hrdata_s[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_ahb_decoder_mux.sv
// Self-checking bench for ahb_decoder_mux: decode table, hand-written
// multi-cycle sequences and a randomized run against a transfer-level model.
module tb_ahb_decoder_mux;
  import ahb_pkg::*;

  localparam int NS = 4;
  localparam int DW = 32;
  localparam logic [31:0] S_ADDR [0:NS-1] = '{32'h0000_2000, 32'h0000_1000, 32'h0000_2000, 32'hFFFF_F000};
  localparam logic [31:0] E_ADDR [0:NS-1] = '{32'h0000_2FFF, 32'h0000_1FFF, 32'h0000_3FFF, 32'hFFFF_FFFF};

  logic             clk;
  logic             rst_n;
  logic [31:0]      haddr;
  logic [1:0]       htrans;
  logic [NS-1:0]    hsel;
  logic [NS-1:0]    hreadyout_s;
  logic [NS-1:0]    hresp_s;
  logic [NS*DW-1:0] hrdata_s;
  logic             hready;
  logic             hresp;
  logic [DW-1:0]    hrdata;

  int checks;
  int errors;

  typedef struct packed {
    logic [31:0]   addr;
    logic [NS-1:0] hsel;
  } vec_t;

  vec_t vecs [12];

  ahb_decoder_mux #(
    .NUM_SLAVES (NS),
    .DATA_WIDTH (DW),
    .START_ADDR (S_ADDR),
    .END_ADDR   (E_ADDR)
  ) dut (
    .i_hclk        (clk),
    .i_hresetn     (rst_n),
    .i_haddr       (haddr),
    .i_htrans      (htrans),
    .o_hsel        (hsel),
    .i_hreadyout_s (hreadyout_s),
    .i_hresp_s     (hresp_s),
    .i_hrdata_s    (hrdata_s),
    .o_hready      (hready),
    .o_hresp       (hresp),
    .o_hrdata      (hrdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Index of the owning slave by region rules, -1 for unmapped space.
  function automatic int decode(input logic [31:0] addr);
    for (int i = 0; i < NS; i++) begin
      if (addr >= S_ADDR[i] && addr <= E_ADDR[i]) return i;
    end
    return -1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] addr, input logic [1:0] trans,
                               input logic [NS-1:0] rdy, input logic [NS-1:0] rsp);
    @(negedge clk);
    haddr       = addr;
    htrans      = trans;
    hreadyout_s = rdy;
    hresp_s     = rsp;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic exp_rdy,
                             input logic exp_rsp, input logic [31:0] exp_data);
    chk({name, ".hready"}, 32'(hready), 32'(exp_rdy));
    chk({name, ".hresp"},  32'(hresp),  32'(exp_rsp));
    chk({name, ".hrdata"}, hrdata, exp_data);
  endtask

  initial begin
    int          m_dsel;
    int          m_err;
    int          idx;
    logic        e_rdy;
    logic        e_rsp;
    logic [31:0] e_data;
    logic [NS-1:0] e_sel;

    checks = 0;
    errors = 0;
    vecs[0]  = '{32'h0000_0000, 4'b0000};
    vecs[1]  = '{32'h0000_0FFF, 4'b0000};
    vecs[2]  = '{32'h0000_1000, 4'b0010};
    vecs[3]  = '{32'h0000_1FFF, 4'b0010};
    vecs[4]  = '{32'h0000_2000, 4'b0001};
    vecs[5]  = '{32'h0000_2FFF, 4'b0001};
    vecs[6]  = '{32'h0000_3000, 4'b0100};
    vecs[7]  = '{32'h0000_3FFF, 4'b0100};
    vecs[8]  = '{32'h0000_4000, 4'b0000};
    vecs[9]  = '{32'hFFFF_EFFF, 4'b0000};
    vecs[10] = '{32'hFFFF_F000, 4'b1000};
    vecs[11] = '{32'hFFFF_FFFF, 4'b1000};

    rst_n       = 1'b0;
    haddr       = '0;
    htrans      = HTRANS_IDLE;
    hreadyout_s = '1;
    hresp_s     = '0;
    for (int i = 0; i < NS; i++) hrdata_s[i*DW +: DW] = 32'hA5A5_0000 | 32'(i);
    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset", 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].addr, HTRANS_IDLE, 4'hF, 4'h0);
      chk($sformatf("decode[%0d]", i), 32'(hsel), 32'(vecs[i].hsel));
    end

    applyStimulus(32'h0000_1FFF, HTRANS_NONSEQ, 4'hF, 4'h0);
    chk("seqA.hsel", 32'(hsel), 32'h2);
    applyStimulus(32'h0, HTRANS_IDLE, 4'hF, 4'h0);
    checkOutput("seqA.data", 1'b1, 1'b0, 32'hA5A5_0001);

    applyStimulus(32'hF000_0000, HTRANS_NONSEQ, 4'hF, 4'h0);
    chk("seqB.hsel", 32'(hsel), 32'h0);
    checkOutput("seqB.addr", 1'b1, 1'b0, 32'h0);
    applyStimulus(32'h0, HTRANS_IDLE, 4'hF, 4'h0);
    checkOutput("seqB.err1", 1'b0, 1'b1, 32'h0);
    applyStimulus(32'h0, HTRANS_IDLE, 4'hF, 4'h0);
    checkOutput("seqB.err2", 1'b1, 1'b1, 32'h0);
    applyStimulus(32'hF000_0000, HTRANS_IDLE, 4'hF, 4'h0);
    checkOutput("seqB.idle", 1'b1, 1'b0, 32'h0);
    applyStimulus(32'h0, HTRANS_IDLE, 4'hF, 4'h0);
    checkOutput("seqB.idleok", 1'b1, 1'b0, 32'h0);

    applyStimulus(32'h0000_2000, HTRANS_NONSEQ, 4'hF, 4'h0);
    checkOutput("seqC.addr", 1'b1, 1'b0, 32'h0);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(32'h0000_1000, HTRANS_NONSEQ, 4'b1110, 4'h0);
      checkOutput($sformatf("seqC.wait%0d", k), 1'b0, 1'b0, 32'hA5A5_0000);
    end
    applyStimulus(32'h0000_1000, HTRANS_NONSEQ, 4'hF, 4'h0);
    checkOutput("seqC.release", 1'b1, 1'b0, 32'hA5A5_0000);
    applyStimulus(32'h0, HTRANS_IDLE, 4'hF, 4'h0);
    checkOutput("seqC.switch", 1'b1, 1'b0, 32'hA5A5_0001);

    applyStimulus(32'hF000_0000, HTRANS_NONSEQ, 4'hF, 4'h0);
    checkOutput("seqD.addr", 1'b1, 1'b0, 32'h0);
    applyStimulus(32'hF000_0004, HTRANS_NONSEQ, 4'hF, 4'h0);
    checkOutput("seqD.err1a", 1'b0, 1'b1, 32'h0);
    applyStimulus(32'hF000_0004, HTRANS_NONSEQ, 4'hF, 4'h0);
    checkOutput("seqD.err2a", 1'b1, 1'b1, 32'h0);
    applyStimulus(32'h0, HTRANS_IDLE, 4'hF, 4'h0);
    checkOutput("seqD.err1b", 1'b0, 1'b1, 32'h0);
    applyStimulus(32'h0000_1000, HTRANS_NONSEQ, 4'hF, 4'h0);
    checkOutput("seqD.err2b", 1'b1, 1'b1, 32'h0);
    applyStimulus(32'h0, HTRANS_IDLE, 4'hF, 4'h0);
    checkOutput("seqD.mapped", 1'b1, 1'b0, 32'hA5A5_0001);

    applyStimulus(32'hF000_0000, HTRANS_NONSEQ, 4'hF, 4'h0);
    checkOutput("seqE.addr", 1'b1, 1'b0, 32'h0);
    applyStimulus(32'h0, HTRANS_IDLE, 4'hF, 4'h0);
    checkOutput("seqE.err1", 1'b0, 1'b1, 32'h0);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("seqE.asyncrst", 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized run; model tracks data-phase owner and remaining error cycles.
    m_dsel = -1;
    m_err  = 0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) haddr = $urandom;
      else haddr = vecs[$urandom_range(0, 11)].addr;
      htrans = 2'($urandom);
      for (int i = 0; i < NS; i++) begin
        hreadyout_s[i] = ($urandom_range(0, 3) != 0);
        hresp_s[i]     = ($urandom_range(0, 3) == 0);
        hrdata_s[i*DW +: DW] = $urandom;
      end
      #1;
      idx   = decode(haddr);
      e_sel = (idx < 0) ? '0 : NS'(1 << idx);
      if (m_dsel >= 0) begin
        e_rdy  = hreadyout_s[m_dsel];
        e_rsp  = hresp_s[m_dsel];
        e_data = hrdata_s[m_dsel*DW +: DW];
      end else begin
        e_rdy  = (m_err != 1);
        e_rsp  = (m_err != 0);
        e_data = 32'h0;
      end
      chk("rand.hsel", 32'(hsel), 32'(e_sel));
      checkOutput("rand", e_rdy, e_rsp, e_data);
      if (m_err == 1) m_err = 2;
      else if (e_rdy && idx < 0 && htrans[1]) m_err = 1;
      else m_err = 0;
      if (e_rdy) m_dsel = idx;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
